// File: rtl/mem_cache_ctrl_if.sv
// MEM-stage request bus plus the word-level SRAM controller handshake seen by the cache.
interface mem_cache_ctrl_if #(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned WORD_LEN = 32
);
    logic [ADDR_LEN-1:0] address;
    logic [WORD_LEN-1:0] writeData;
    logic                MEM_R_EN;
    logic                MEM_W_EN;
    logic [WORD_LEN-1:0] rdata;
    logic                ready;
    logic [ADDR_LEN-1:0] sram_address;
    logic [WORD_LEN-1:0] sram_write_data;
    logic                sram_write_en;
    logic                sram_read_en;
    logic [WORD_LEN-1:0] sram_read_data;
    logic                sram_ready;
    logic [15:0]         hit_count;
    logic [15:0]         miss_count;

    // Cache side
    modport slave (
        input  address, writeData, MEM_R_EN, MEM_W_EN, sram_read_data, sram_ready,
        output rdata, ready, sram_address, sram_write_data, sram_write_en, sram_read_en,
               hit_count, miss_count
    );

    // Pipeline / SRAM-controller side
    modport master (
        output address, writeData, MEM_R_EN, MEM_W_EN, sram_read_data, sram_ready,
        input  rdata, ready, sram_address, sram_write_data, sram_write_en, sram_read_en,
               hit_count, miss_count
    );
endinterface

// File: rtl/mem_cache_ctrl.sv
// Set-associative write-through, no-write-allocate data cache with LRU replacement
// and critical-word-first line fill.
module mem_cache_ctrl #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 2,
    parameter int unsigned ADDR_LEN   = 32,
    parameter int unsigned WORD_LEN   = 32
) (
    input logic             clk,
    input logic             rst,
    mem_cache_ctrl_if.slave bus
);
    localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned TAG_BITS = ADDR_LEN - 2 - OFF_BITS - IDX_BITS;
    localparam int unsigned OFF_W    = (OFF_BITS == 0) ? 1 : OFF_BITS;
    localparam int unsigned LEFT_W   = $clog2(LINE_WORDS + 1);
    localparam logic [ADDR_LEN-1:0] LINE_MASK = ADDR_LEN'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

    state_t                state_q;
    logic [WORD_LEN-1:0]   data_q  [WAYS][SETS][LINE_WORDS];
    logic [TAG_BITS-1:0]   tag_q   [WAYS][SETS];
    logic [SETS-1:0]       valid_q [WAYS];
    logic [SETS-1:0]       lru_q;
    logic [15:0]           hit_count_q, miss_count_q;
    logic [OFF_W-1:0]      cnt_q;
    logic [LEFT_W-1:0]     words_left_q;
    logic                  victim_q;
    logic [IDX_BITS-1:0]   fill_idx_q;
    logic [TAG_BITS-1:0]   fill_tag_q;
    logic [ADDR_LEN-1:0]   line_base_q;
    logic [ADDR_LEN-1:0]   sram_address_q;
    logic [WORD_LEN-1:0]   sram_write_data_q;
    logic                  sram_write_en_q, sram_read_en_q;

    logic [ADDR_LEN-1:0]   word_addr;
    logic [OFF_W-1:0]      req_off;
    logic [IDX_BITS-1:0]   req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [OFF_W-1:0]      cnt_next;
    logic                  hit, hit_way, victim_c, fill_last;
    logic [WORD_LEN-1:0]   hit_word;

    // Address split: byte bits dropped, then offset, index, tag
    assign word_addr = bus.address >> 2;
    assign req_off   = OFF_W'(word_addr & ADDR_LEN'(LINE_WORDS - 1));
    assign req_idx   = IDX_BITS'(word_addr >> OFF_BITS);
    assign req_tag   = TAG_BITS'(word_addr >> (OFF_BITS + IDX_BITS));
    assign cnt_next  = OFF_W'((32'(cnt_q) + 32'd1) % LINE_WORDS);
    assign fill_last = (words_left_q == LEFT_W'(1));

    // Combinational tag lookup across all ways
    always_comb begin
        hit      = 1'b0;
        hit_way  = 1'b0;
        hit_word = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit      = 1'b1;
                hit_way  = 1'(w);
                hit_word = data_q[w][req_idx][req_off];
            end
        end
    end

    // Victim choice: lowest invalid way, otherwise the LRU way of the set
    always_comb begin
        victim_c = (WAYS > 1) ? lru_q[req_idx] : 1'b0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx]) begin
                victim_c = 1'(w);
            end
        end
    end

    // Freeze and load data are combinational so hits and store completion cost no cycle
    always_comb begin
        bus.ready = 1'b0;
        bus.rdata = '0;
        if (rst) begin
            bus.ready = 1'b1;
        end else begin
            bus.rdata = hit ? hit_word : '0;
            case (state_q)
                IDLE:    bus.ready = !bus.MEM_W_EN && !(bus.MEM_R_EN && !hit);
                WRITE:   bus.ready = bus.sram_ready;
                default: bus.ready = 1'b0;
            endcase
        end
    end

    // Controller FSM, valid/LRU state, counters and SRAM request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            for (int w = 0; w < int'(WAYS); w++) begin
                valid_q[w] <= '0;
            end
            lru_q             <= '0;
            hit_count_q       <= '0;
            miss_count_q      <= '0;
            cnt_q             <= '0;
            words_left_q      <= '0;
            victim_q          <= 1'b0;
            fill_idx_q        <= '0;
            fill_tag_q        <= '0;
            line_base_q       <= '0;
            sram_address_q    <= '0;
            sram_write_data_q <= '0;
            sram_write_en_q   <= 1'b0;
            sram_read_en_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.MEM_W_EN) begin
                        state_q           <= WRITE;
                        sram_write_en_q   <= 1'b1;
                        sram_address_q    <= {bus.address[ADDR_LEN-1:2], 2'b00};
                        sram_write_data_q <= bus.writeData;
                    end else if (bus.MEM_R_EN) begin
                        if (hit) begin
                            lru_q[req_idx] <= ~hit_way;
                            if (hit_count_q != 16'hFFFF) begin
                                hit_count_q <= hit_count_q + 16'd1;
                            end
                        end else begin
                            if (miss_count_q != 16'hFFFF) begin
                                miss_count_q <= miss_count_q + 16'd1;
                            end
                            // Invalidate the victim now so a half-filled line can never hit
                            valid_q[victim_c][req_idx] <= 1'b0;
                            victim_q       <= victim_c;
                            cnt_q          <= req_off;
                            words_left_q   <= LEFT_W'(LINE_WORDS);
                            fill_idx_q     <= req_idx;
                            fill_tag_q     <= req_tag;
                            line_base_q    <= bus.address & ~LINE_MASK;
                            sram_address_q <= {bus.address[ADDR_LEN-1:2], 2'b00};
                            sram_read_en_q <= 1'b1;
                            state_q        <= FILL;
                        end
                    end
                end
                WRITE: begin
                    if (bus.sram_ready) begin
                        sram_write_en_q <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                FILL: begin
                    if (bus.sram_ready) begin
                        cnt_q        <= cnt_next;
                        words_left_q <= words_left_q - LEFT_W'(1);
                        if (fill_last) begin
                            valid_q[victim_q][fill_idx_q] <= 1'b1;
                            sram_read_en_q <= 1'b0;
                            state_q        <= IDLE;
                        end else begin
                            sram_address_q <= line_base_q | (ADDR_LEN'(cnt_next) << 2);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data and tag arrays: store-hit word update and line fill capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state_q == WRITE) && bus.sram_ready && hit) begin
                data_q[hit_way][req_idx][req_off] <= bus.writeData;
            end
            if ((state_q == FILL) && bus.sram_ready) begin
                data_q[victim_q][fill_idx_q][cnt_q] <= bus.sram_read_data;
                if (fill_last) begin
                    tag_q[victim_q][fill_idx_q] <= fill_tag_q;
                end
            end
        end
    end

    assign bus.sram_address    = sram_address_q;
    assign bus.sram_write_data = sram_write_data_q;
    assign bus.sram_write_en   = sram_write_en_q;
    assign bus.sram_read_en    = sram_read_en_q;
    assign bus.hit_count       = hit_count_q;
    assign bus.miss_count      = miss_count_q;

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Directed bench: 2-way, 64 sets, 2-word lines, behind a 3-cycle SRAM model.
module tb_mem_cache_ctrl;
    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_cache_ctrl_if #(.ADDR_LEN(32), .WORD_LEN(32)) bus ();

    mem_cache_ctrl #(
        .WAYS(2), .SETS(64), .LINE_WORDS(2), .ADDR_LEN(32), .WORD_LEN(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // SRAM model state
    logic [31:0] wmem [logic [31:0]];
    logic [31:0] rd_log [$];
    int          n_rd = 0;
    int          n_wr = 0;
    int          lat_cnt = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    // Untouched SRAM words read back as C0DE in the upper half, address in the lower half
    function automatic logic [31:0] sram_val(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return {16'hC0DE, a[15:0]};
    endfunction

    // SRAM controller model: one-cycle ready pulse LAT cycles after a request is first seen
    always @(posedge clk) begin
        if (rst) begin
            bus.sram_ready     <= 1'b0;
            bus.sram_read_data <= '0;
            lat_cnt            = 0;
        end else if ((bus.sram_read_en || bus.sram_write_en) && !bus.sram_ready) begin
            if (lat_cnt == int'(LAT) - 1) begin
                lat_cnt = 0;
                bus.sram_ready <= 1'b1;
                if (bus.sram_write_en) begin
                    wmem[bus.sram_address] = bus.sram_write_data;
                    last_wa = bus.sram_address;
                    last_wd = bus.sram_write_data;
                    n_wr++;
                end else begin
                    bus.sram_read_data <= sram_val(bus.sram_address);
                    rd_log.push_back(bus.sram_address);
                    n_rd++;
                end
            end else begin
                lat_cnt++;
            end
        end else begin
            bus.sram_ready <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Issue a load; lat = negedges after the request cycle until ready (-1 on timeout)
    task automatic do_read(input logic [31:0] a, output logic [31:0] data, output int lat);
        @(posedge clk); #1;
        bus.address  = a;
        bus.MEM_R_EN = 1'b1;
        data = 'x;
        lat  = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                data = bus.rdata;
                lat  = c;
                break;
            end
        end
        @(posedge clk); #1;
        bus.MEM_R_EN = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int lat);
        @(posedge clk); #1;
        bus.address   = a;
        bus.writeData = d;
        bus.MEM_W_EN  = 1'b1;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                lat = c;
                break;
            end
        end
        @(posedge clk); #1;
        bus.MEM_W_EN = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lat;
        int          rd0;
        int          wr0;

        rst           = 1'b1;
        bus.address   = '0;
        bus.writeData = '0;
        bus.MEM_R_EN  = 1'b0;
        bus.MEM_W_EN  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset: ready forced high and rdata zero even with a load pending
        @(negedge clk);
        bus.address  = 32'h404;
        bus.MEM_R_EN = 1'b1;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_rdata", bus.rdata, 32'h0);
        bus.MEM_R_EN = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_hits", 32'(bus.hit_count), 32'd0);
        check("rst_miss", 32'(bus.miss_count), 32'd0);
        check("rst_rden", 32'(bus.sram_read_en), 32'd0);
        check("rst_wren", 32'(bus.sram_write_en), 32'd0);
        check("rst_saddr", bus.sram_address, 32'h0);

        // Cold miss, critical word first
        do_read(32'h404, d, lat);
        check("cold_lat", 32'(lat), 32'd9);
        check("cold_data", d, 32'hC0DE0404);
        check("cold_nrd", 32'(n_rd), 32'd2);
        check("cold_rd0", rd_log[0], 32'h404);
        check("cold_rd1", rd_log[1], 32'h400);
        check("cold_miss", 32'(bus.miss_count), 32'd1);
        check("cold_hits", 32'(bus.hit_count), 32'd1);

        // Other word of the same line hits with no SRAM traffic
        do_read(32'h400, d, lat);
        check("line_lat", 32'(lat), 32'd0);
        check("line_data", d, 32'hC0DE0400);
        check("line_nrd", 32'(n_rd), 32'd2);
        check("line_hits", 32'(bus.hit_count), 32'd2);

        // Store hit: one SRAM write, cached word updated
        do_write(32'h404, 32'hDEADBEEF, lat);
        check("wr_lat", 32'(lat), 32'd4);
        check("wr_nwr", 32'(n_wr), 32'd1);
        check("wr_addr", last_wa, 32'h404);
        check("wr_data", last_wd, 32'hDEADBEEF);
        do_read(32'h404, d, lat);
        check("wrhit_lat", 32'(lat), 32'd0);
        check("wrhit_data", d, 32'hDEADBEEF);
        check("wrhit_hits", 32'(bus.hit_count), 32'd3);

        // LRU: 0x600 fills way 1, 0x400 touched, 0x800 evicts 0x600
        do_read(32'h400, d, lat);
        check("lru_a_lat", 32'(lat), 32'd0);
        do_read(32'h600, d, lat);
        check("lru_b_lat", 32'(lat), 32'd9);
        check("lru_b_data", d, 32'hC0DE0600);
        do_read(32'h400, d, lat);
        check("lru_c_lat", 32'(lat), 32'd0);
        do_read(32'h800, d, lat);
        check("lru_d_lat", 32'(lat), 32'd9);
        check("lru_d_data", d, 32'hC0DE0800);
        check("lru_d_miss", 32'(bus.miss_count), 32'd3);
        do_read(32'h400, d, lat);
        check("lru_e_lat", 32'(lat), 32'd0);
        check("lru_e_data", d, 32'hC0DE0400);
        do_read(32'h600, d, lat);
        check("lru_f_lat", 32'(lat), 32'd9);
        check("lru_f_miss", 32'(bus.miss_count), 32'd4);
        check("lru_f_hits", 32'(bus.hit_count), 32'd9);

        // Store miss does not allocate; the following load fills from SRAM
        rd0 = n_rd;
        wr0 = n_wr;
        do_write(32'hC00, 32'h12345678, lat);
        check("nwa_lat", 32'(lat), 32'd4);
        check("nwa_nwr", 32'(n_wr - wr0), 32'd1);
        check("nwa_nrd", 32'(n_rd - rd0), 32'd0);
        do_read(32'hC00, d, lat);
        check("nwa_rlat", 32'(lat), 32'd9);
        check("nwa_data", d, 32'h12345678);
        check("nwa_miss", 32'(bus.miss_count), 32'd5);

        // Reset during the second word of a fill
        @(posedge clk); #1;
        bus.address  = 32'h1000;
        bus.MEM_R_EN = 1'b1;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.sram_ready) begin
                lat = c;
                break;
            end
        end
        check("rf_first", 32'(lat), 32'd4);
        @(negedge clk);
        check("rf_rden", 32'(bus.sram_read_en), 32'd1);
        check("rf_addr2", bus.sram_address, 32'h1004);
        rst          = 1'b1;
        bus.MEM_R_EN = 1'b0;
        #1;
        check("rf_rst_ready", 32'(bus.ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rf_rden0", 32'(bus.sram_read_en), 32'd0);
        check("rf_hits0", 32'(bus.hit_count), 32'd0);
        check("rf_miss0", 32'(bus.miss_count), 32'd0);
        do_read(32'h1000, d, lat);
        check("rf_re_lat", 32'(lat), 32'd9);
        check("rf_re_data", d, 32'hC0DE1000);
        check("rf_re_miss", 32'(bus.miss_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
